// File: rtl/transpose_pkg.sv
// Shared types and lane-index helpers for the tile transpose sequencer.
// Callers keep the low ADDR_WIDTH bits of the helper results, giving mod NUM_PE.
package transpose_pkg;

  typedef enum logic {
    ST_FILL,
    ST_DRAIN
  } state_e;

  localparam int unsigned IDX_W = 8;
  typedef logic [IDX_W-1:0] idx_t;

  function automatic idx_t rot_idx(input idx_t a, input idx_t b);
    return a + b;
  endfunction

  function automatic idx_t skew_idx(input idx_t a, input idx_t b);
    return a - b;
  endfunction

endpackage

// File: rtl/transpose_out_fifo.sv
// Two-entry valid/ready column buffer; occupancy is exported for read throttling.
module transpose_out_fifo
  import transpose_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned NUM_PE     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_data_i [0:NUM_PE-1],
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] head_o      [0:NUM_PE-1],
  output logic [1:0]            occ_o
);

  logic [DATA_WIDTH-1:0] mem_q [0:1][0:NUM_PE-1];
  logic                  wr_ptr_q;
  logic                  rd_ptr_q;
  logic [1:0]            occ_q, occ_d;
  logic                  push_ok, pop_ok;

  always_comb begin
    pop_ok  = pop_i && (occ_q != 2'd0);
    push_ok = push_i && ((occ_q != 2'd2) || pop_ok);
    occ_d   = occ_q;
    if (push_ok && !pop_ok) begin
      occ_d = occ_q + 2'd1;
    end else if (!push_ok && pop_ok) begin
      occ_d = occ_q - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < 2; i++) begin
        for (int unsigned j = 0; j < NUM_PE; j++) begin
          mem_q[i][j] <= '0;
        end
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_ok) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      occ_q <= occ_d;
    end
  end

  assign head_o = mem_q[rd_ptr_q];
  assign occ_o  = occ_q;

endmodule

// File: rtl/transpose_ctrl.sv
// Single-buffered NUM_PE x NUM_PE tile transposer: rows are written skewed
// across the banks, columns are read back conflict-free and un-rotated.
module transpose_ctrl
  import transpose_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned NUM_PE     = 4,
  parameter int unsigned ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data         [0:NUM_PE-1],
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data        [0:NUM_PE-1],
  output logic                  tile_done,
  output logic                  bank_wen,
  output logic [ADDR_WIDTH-1:0] bank_write_addr [0:NUM_PE-1],
  output logic [DATA_WIDTH-1:0] bank_write_data [0:NUM_PE-1],
  output logic                  bank_ren,
  output logic [ADDR_WIDTH-1:0] bank_read_addr  [0:NUM_PE-1],
  input  logic [DATA_WIDTH-1:0] bank_read_data  [0:NUM_PE-1]
);

  if (ADDR_WIDTH != $clog2(NUM_PE)) begin : g_bad_addr_width
    $error("transpose_ctrl: ADDR_WIDTH must equal $clog2(NUM_PE)");
  end
  if ((NUM_PE < 2) || ((NUM_PE & (NUM_PE - 1)) != 0)) begin : g_bad_num_pe
    $error("transpose_ctrl: NUM_PE must be a power of two >= 2");
  end

  localparam logic [ADDR_WIDTH:0]   NUM_COLS = (ADDR_WIDTH + 1)'(NUM_PE);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_PE - 1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] row_cnt_q, row_cnt_d;
  logic [ADDR_WIDTH:0]   col_cnt_q, col_cnt_d;
  logic [ADDR_WIDTH-1:0] out_cnt_q, out_cnt_d;
  logic [ADDR_WIDTH-1:0] rd_col_q, rd_col_d;
  logic                  inflight_q, inflight_d;

  logic [DATA_WIDTH-1:0] fifo_push_data [0:NUM_PE-1];
  logic [DATA_WIDTH-1:0] fifo_head      [0:NUM_PE-1];
  logic [1:0]            fifo_occ;
  logic                  pop;
  logic [2:0]            busy, limit;
  logic [ADDR_WIDTH-1:0] ix;

  transpose_out_fifo #(
    .DATA_WIDTH(DATA_WIDTH),
    .NUM_PE    (NUM_PE)
  ) u_out_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (inflight_q),
    .push_data_i(fifo_push_data),
    .pop_i      (pop),
    .head_o     (fifo_head),
    .occ_o      (fifo_occ)
  );

  always_comb begin
    state_d    = state_q;
    row_cnt_d  = row_cnt_q;
    col_cnt_d  = col_cnt_q;
    out_cnt_d  = out_cnt_q;
    rd_col_d   = rd_col_q;
    inflight_d = 1'b0;
    in_ready   = 1'b0;
    bank_wen   = 1'b0;
    bank_ren   = 1'b0;
    tile_done  = 1'b0;
    out_valid  = 1'b0;
    pop        = 1'b0;
    ix         = '0;
    busy       = {1'b0, fifo_occ} + {2'b00, inflight_q};
    limit      = 3'd2;
    for (int unsigned b = 0; b < NUM_PE; b++) begin
      bank_write_addr[b] = '0;
      bank_write_data[b] = '0;
      bank_read_addr[b]  = '0;
      fifo_push_data[b]  = '0;
      out_data[b]        = '0;
    end

    if (rst) begin
      out_valid = (fifo_occ != 2'd0);
      pop       = out_valid && out_ready;
      for (int unsigned r = 0; r < NUM_PE; r++) begin
        out_data[r]       = fifo_head[r];
        ix                = ADDR_WIDTH'(rot_idx(idx_t'(rd_col_q), idx_t'(r)));
        fifo_push_data[r] = bank_read_data[ix];
      end

      unique case (state_q)
        ST_FILL: begin
          in_ready = 1'b1;
          if (in_valid) begin
            bank_wen  = 1'b1;
            row_cnt_d = row_cnt_q + 1'b1;
            for (int unsigned b = 0; b < NUM_PE; b++) begin
              ix                 = ADDR_WIDTH'(skew_idx(idx_t'(b), idx_t'(row_cnt_q)));
              bank_write_addr[b] = row_cnt_q;
              bank_write_data[b] = in_data[ix];
            end
            if (row_cnt_q == LAST_IDX) begin
              state_d = ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          // A slot freed by this cycle's pop is reusable now, keeping 1 column/cycle.
          if (pop) begin
            limit = 3'd3;
          end
          if ((col_cnt_q < NUM_COLS) && (busy < limit)) begin
            bank_ren   = 1'b1;
            inflight_d = 1'b1;
            rd_col_d   = col_cnt_q[ADDR_WIDTH-1:0];
            col_cnt_d  = col_cnt_q + 1'b1;
            for (int unsigned b = 0; b < NUM_PE; b++) begin
              bank_read_addr[b] = ADDR_WIDTH'(skew_idx(idx_t'(b),
                                    idx_t'(col_cnt_q[ADDR_WIDTH-1:0])));
            end
          end
          if (pop) begin
            out_cnt_d = out_cnt_q + 1'b1;
            if (out_cnt_q == LAST_IDX) begin
              tile_done = 1'b1;
              state_d   = ST_FILL;
              col_cnt_d = '0;
            end
          end
        end
        default: state_d = ST_FILL;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_FILL;
      row_cnt_q  <= '0;
      col_cnt_q  <= '0;
      out_cnt_q  <= '0;
      rd_col_q   <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_cnt_q  <= row_cnt_d;
      col_cnt_q  <= col_cnt_d;
      out_cnt_q  <= out_cnt_d;
      rd_col_q   <= rd_col_d;
      inflight_q <= inflight_d;
    end
  end

endmodule

// File: doc/transpose_ctrl.md
Name: transpose_ctrl

Overview:
- Sequencer for transpose_memory_bank. Transposes one NUM_PE x NUM_PE tile.
- Accepts the tile row by row (NUM_PE lanes per beat) and streams it out column by column.
- Drives the bank's per-PE write/read address and data vectors.
- Stores rows diagonally (skewed) so every row write and every column read touches each bank exactly once, with no conflicts.
- Sits between the upstream PE row stream and the downstream consumer. Single buffer: a tile must fully drain before the next fill starts.

Parameters:
- DATA_WIDTH, 16, lane data width.
- NUM_PE, 4, lanes, banks and tile dimension. Power of two, >=2.
- ADDR_WIDTH, 2, bank address width. Must equal $clog2(NUM_PE); elaboration error otherwise.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset.
- in_valid  in  1  upstream row valid.
- in_ready  out  1  controller accepts row.
- in_data  in  NUM_PE x DATA_WIDTH (unpacked [0:NUM_PE-1])  row r, lane j = element (r,j).
- out_valid  out  1  column valid.
- out_ready  in  1  downstream accepts column.
- out_data  out  NUM_PE x DATA_WIDTH  column c, lane r = element (r,c).
- tile_done  out  1  one-cycle pulse on the handshake of column NUM_PE-1.
- bank_wen  out  1  to bank wen.
- bank_write_addr  out  NUM_PE x ADDR_WIDTH  to bank write_addr.
- bank_write_data  out  NUM_PE x DATA_WIDTH  to bank write_data.
- bank_ren  out  1  to bank ren.
- bank_read_addr  out  NUM_PE x ADDR_WIDTH  to bank read_addr.
- bank_read_data  in  NUM_PE x DATA_WIDTH  from bank read_data.

Behaviour:
- Bank contract:
  - Bank b holds one word per address.
  - read_data is valid the cycle after ren=1.
  - A write committed at edge E is visible to a read issued in the cycle after E.
- Reset (rst=0 at a clock edge):
  - state=FILL, row_cnt=0, col_cnt=0, FIFO empty, in-flight flag clear.
  - in_ready=0 while rst=0. out_valid=0, tile_done=0, bank_wen=0, bank_ren=0.
  - All address and data outputs are 0.
  - Reset mid-fill or mid-drain discards the tile. No stale out_valid after reset.
- FILL:
  - in_ready=1.
  - On in_valid & in_ready with row r=row_cnt: bank_wen=1 combinationally in that cycle.
  - For each bank b: bank_write_addr[b]=r, bank_write_data[b]=in_data[(b-r) mod NUM_PE].
  - Equivalent statement: element (r,j) goes to bank (j+r) mod NUM_PE.
  - row_cnt increments. On accepting row NUM_PE-1, row_cnt wraps to 0 and the next state is DRAIN.
  - bank_wen=0 when there is no handshake.
- DRAIN:
  - in_ready=0. in_valid is ignored.
  - Issues column read c=col_cnt when (FIFO occupancy + in-flight) < 2 and col_cnt has not yet issued NUM_PE reads.
  - On issue: bank_ren=1 and bank_read_addr[b]=(b-c) mod NUM_PE.
  - The next cycle, the FIFO captures the rotated word, lane r = bank_read_data[(c+r) mod NUM_PE].
  - out_valid for column c asserts 2 cycles after its bank_ren cycle.
  - Steady-state throughput is 1 column/cycle with out_ready=1.
- Output FIFO:
  - 2 entries. out_data is the head. out_valid=(occupancy!=0).
  - out_data is held stable while out_valid & !out_ready.
  - Simultaneous push and pop keeps occupancy unchanged.
- Drain completion:
  - tile_done pulses in the cycle of the handshake of column NUM_PE-1.
  - On that edge, state returns to FILL and col_cnt returns to 0.
  - in_ready=1 in the following cycle.
- Arithmetic: all mod-NUM_PE index math is ADDR_WIDTH-bit unsigned wrap. No other arithmetic.

Decomposition:
- Package transpose_pkg:
  - state enum {ST_FILL, ST_DRAIN}.
  - Function rot_idx(a,b) returning (a+b) mod NUM_PE.
  - Function skew_idx(a,b) returning (a-b) mod NUM_PE.
- Sub-module transpose_out_fifo:
  - 2-entry, NUM_PE x DATA_WIDTH, valid/ready.
  - Exposes occupancy for read-issue throttling.
- FSM, counters and permutation logic live in transpose_ctrl.

Test Plan:
- Reset and idle:
  - Stimulus: hold rst=0 for 3 cycles with in_valid=1, then release.
  - Required: in_ready, out_valid, bank_wen and bank_ren all 0 during reset; in_ready=1 the first cycle after release.
- Skewed write:
  - Stimulus: in_data[j]=16'h0010*r+j for rows r=0..3, in_valid held high.
  - Required: bank_wen=1 for 4 consecutive cycles.
  - Required at row 1: bank_write_addr all 1, bank_write_data={16'h0013,16'h0010,16'h0011,16'h0012}.
- Column output:
  - Stimulus: same tile, out_ready=1.
  - Required: 4 columns on consecutive cycles. Column 2 = {16'h0002,16'h0012,16'h0022,16'h0032}.
  - Required: bank_read_addr for c=1 = {3,0,1,2}. tile_done pulses with column 3.
- Backpressure:
  - Stimulus: out_ready=0 for 6 cycles starting in DRAIN.
  - Required: at most 2 bank_ren pulses issued. out_data stable at column 0 until out_ready rises.
  - Required: order 0..3 preserved with no loss or duplication.
- Input ignored during drain:
  - Stimulus: in_valid=1 throughout DRAIN.
  - Required: in_ready=0, bank_wen=0. The next tile's row 0 is accepted the cycle after tile_done.
- Reset mid-drain:
  - Stimulus: rst=0 after column 1 handshakes.
  - Required: out_valid=0 the cycle after that reset edge.
  - Required: a new tile 16'h0100+0x10*r+j transposes correctly with no residue from the old tile.
